// File: rtl/video_wr_arbiter.sv
// video_wr_arbiter
// Arbitrates four sampler channels onto one AXI write port. Each granted
// channel gets one fixed-length burst into its current ping/pong frame buffer.
// Full FIFOs win over plain round-robin. A frame start rewinds the channel's
// buffer address. A channel that has written a whole frame is masked until its
// next frame start.

module video_wr_arbiter #(
    parameter int          DQ_WIDTH     = 32,
    parameter int          BURST_LEN    = 8,
    parameter int          FRAME_BURSTS = 450,
    parameter logic [31:0] ADDR_BASE    = 32'h0,
    parameter logic [31:0] CH_STRIDE    = 32'h40000,
    parameter logic [31:0] FRAME_BYTES  = 32'h20000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [3:0]                ch_ready_i,
    input  logic [3:0]                ch_full_i,
    input  logic [15:0]               ch_trans_id_i,
    input  logic [4*DQ_WIDTH*8-1:0]   ch_data_i,
    input  logic [3:0]                ch_vs_i,
    output logic [3:0]                ch_rd_en_o,
    output logic [31:0]               axi_awaddr_o,
    output logic [7:0]                axi_awlen_o,
    output logic [3:0]                axi_awid_o,
    output logic                      axi_awvalid_o,
    input  logic                      axi_awready_i,
    output logic [DQ_WIDTH*8-1:0]     axi_wdata_o,
    output logic [DQ_WIDTH-1:0]       axi_wstrb_o,
    output logic                      axi_wlast_o,
    output logic                      axi_wvalid_o,
    input  logic                      axi_wready_i,
    input  logic                      axi_bvalid_i,
    output logic                      axi_bready_o,
    output logic [3:0]                wr_frame_idx_o,
    output logic [3:0]                ch_overrun_o
);

    localparam int DATA_W      = DQ_WIDTH * 8;
    localparam int BURST_BYTES = BURST_LEN * DQ_WIDTH;
    localparam int CNT_W       = $clog2(FRAME_BURSTS + 1);
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  FRAME_DONE = CNT_W'(FRAME_BURSTS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  burst_cnt_q [4];
    logic [CNT_W-1:0]  burst_cnt_d [4];
    logic [3:0]        frame_idx_q, frame_idx_d;
    logic [3:0]        mask_q, mask_d;
    logic [3:0]        pend_q, pend_d;
    logic [3:0]        overrun_q, overrun_d;

    logic [3:0]        eligible;
    logic [3:0]        urgent;
    logic              grant_valid;
    logic [1:0]        grant_ch;
    logic [1:0]        idx;
    logic              burst_done;
    logic [CNT_W-1:0]  next_cnt;
    logic              busy;
    logic [31:0]       cur_addr;
    logic              in_aw, in_w, in_b;

    // Pick the next channel: a full FIFO beats round-robin, both searched from the pointer
    always_comb begin
        eligible    = ch_ready_i & ~mask_q;
        urgent      = eligible & ch_full_i;
        grant_valid = |eligible;
        grant_ch    = ptr_q;
        idx         = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (eligible[idx]) grant_ch = idx;
        end
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (urgent[idx]) grant_ch = idx;
        end
    end

    // Burst sequencing: address phase, data beats, then wait for the write response
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        burst_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    sel_d   = grant_ch;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (axi_awready_i) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (axi_wready_i) begin
                    if (beat_q == LAST_BEAT) state_d = S_B;
                    else                     beat_d  = beat_q + 1'b1;
                end
            end
            S_B: begin
                if (axi_bvalid_i) begin
                    burst_done = 1'b1;
                    ptr_d      = sel_q + 2'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-channel frame bookkeeping; a frame start on the active channel waits for the burst to finish
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        frame_idx_d = frame_idx_q;
        mask_d      = mask_q;
        pend_d      = pend_q;
        overrun_d   = overrun_q | (ch_ready_i & mask_q);
        next_cnt    = '0;
        busy        = 1'b0;
        for (int c = 0; c < 4; c++) begin
            busy     = (state_q != S_IDLE) && (sel_q == 2'(c));
            next_cnt = burst_cnt_q[c] + 1'b1;
            if (busy) begin
                if (ch_vs_i[c]) pend_d[c] = 1'b1;
                if (burst_done) begin
                    if (pend_q[c] || ch_vs_i[c]) begin
                        frame_idx_d[c] = ~frame_idx_q[c];
                        burst_cnt_d[c] = '0;
                        mask_d[c]      = 1'b0;
                        pend_d[c]      = 1'b0;
                    end else begin
                        burst_cnt_d[c] = next_cnt;
                        if (next_cnt == FRAME_DONE) mask_d[c] = 1'b1;
                    end
                end
            end else if (ch_vs_i[c]) begin
                frame_idx_d[c] = ~frame_idx_q[c];
                burst_cnt_d[c] = '0;
                mask_d[c]      = 1'b0;
                pend_d[c]      = 1'b0;
            end
        end
    end

    // State registers, with reset overriding everything including an in-flight burst
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            beat_q      <= '0;
            burst_cnt_q <= '{default: '0};
            frame_idx_q <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            overrun_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            burst_cnt_q <= burst_cnt_d;
            frame_idx_q <= frame_idx_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
        end
    end

    // AXI and FIFO-side outputs, all zero outside the phase that owns them
    always_comb begin
        in_aw    = (state_q == S_AW);
        in_w     = (state_q == S_W);
        in_b     = (state_q == S_B);
        cur_addr = ADDR_BASE
                 + CH_STRIDE * 32'(sel_q)
                 + (frame_idx_q[sel_q] ? FRAME_BYTES : 32'd0)
                 + 32'(burst_cnt_q[sel_q]) * 32'(BURST_BYTES);

        axi_awvalid_o = in_aw;
        axi_awaddr_o  = in_aw ? cur_addr : 32'd0;
        axi_awlen_o   = in_aw ? 8'(BURST_LEN - 1) : 8'd0;
        axi_awid_o    = in_aw ? ch_trans_id_i[{sel_q, 2'b00} +: 4] : 4'd0;

        axi_wvalid_o  = in_w;
        axi_wdata_o   = in_w ? ch_data_i[sel_q * DATA_W +: DATA_W] : '0;
        axi_wstrb_o   = in_w ? '1 : '0;
        axi_wlast_o   = in_w && (beat_q == LAST_BEAT);
        axi_bready_o  = in_b;

        ch_rd_en_o    = (in_w && axi_wready_i && !mask_q[sel_q]) ? (4'b0001 << sel_q) : 4'b0000;

        wr_frame_idx_o = frame_idx_q;
        ch_overrun_o   = overrun_q;
    end

endmodule

// File: tb/tb_video_wr_arbiter.sv
// tb_video_wr_arbiter
// Directed scenarios for the DDR write arbiter: reset, single-channel bursts,
// round-robin order, full-FIFO priority, write back-pressure, frame switching
// and end-of-frame overrun.

module tb_video_wr_arbiter;

    logic          clk = 1'b0;
    logic          rstN;
    logic [3:0]    chReady, chFull, chVs;
    logic [15:0]   chTransId;
    logic [1023:0] chDataBus;
    logic [3:0]    rdEn;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [3:0]    awid;
    logic          awvalid, awready;
    logic [255:0]  wdata;
    logic [31:0]   wstrb;
    logic          wlast, wvalid, wready, bvalid, bready;
    logic [3:0]    wrFrameIdx, overrun;

    int compared   = 0;
    int mismatched = 0;

    int           wordIdx [4];
    logic [31:0]  awAddrQ [$];
    logic [3:0]   awIdQ [$];
    logic [7:0]   awLenQ [$];
    logic [255:0] wdataQ [$];
    int           wlastPosQ [$];
    int           rdCount [4];
    int           beatInBurst, beatsTotal, holdChanges, stallCycles;
    logic         holdValid;
    logic [255:0] holdData;
    logic [31:0]  lastWstrb;

    always #5 clk = ~clk;

    video_wr_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .ch_ready_i    (chReady),
        .ch_full_i     (chFull),
        .ch_trans_id_i (chTransId),
        .ch_data_i     (chDataBus),
        .ch_vs_i       (chVs),
        .ch_rd_en_o    (rdEn),
        .axi_awaddr_o  (awaddr),
        .axi_awlen_o   (awlen),
        .axi_awid_o    (awid),
        .axi_awvalid_o (awvalid),
        .axi_awready_i (awready),
        .axi_wdata_o   (wdata),
        .axi_wstrb_o   (wstrb),
        .axi_wlast_o   (wlast),
        .axi_wvalid_o  (wvalid),
        .axi_wready_i  (wready),
        .axi_bvalid_i  (bvalid),
        .axi_bready_o  (bready),
        .wr_frame_idx_o(wrFrameIdx),
        .ch_overrun_o  (overrun)
    );

    // FIFO word k of channel c; the bench FIFO advances one word per rd_en pulse
    function automatic logic [255:0] fifoWord(input int c, input int k);
        return {32'hC0DE0000 | 32'(c), 192'd0, 32'(k)};
    endfunction

    assign chDataBus = {fifoWord(3, wordIdx[3]), fifoWord(2, wordIdx[2]),
                        fifoWord(1, wordIdx[1]), fifoWord(0, wordIdx[0])};

    // Passive bus log sampled mid-cycle; FIFO pops are applied just after the edge
    initial begin
        logic [3:0] popNow;
        for (int c = 0; c < 4; c++) wordIdx[c] = 0;
        forever begin
            @(negedge clk);
            popNow = 4'b0000;
            if (rstN) begin
                popNow = rdEn;
                if (awvalid && awready) begin
                    awAddrQ.push_back(awaddr);
                    awIdQ.push_back(awid);
                    awLenQ.push_back(awlen);
                end
                if (wvalid && wready) begin
                    if (holdValid && wdata !== holdData) holdChanges++;
                    holdValid = 1'b0;
                    wdataQ.push_back(wdata);
                    lastWstrb = wstrb;
                    beatInBurst++;
                    beatsTotal++;
                    if (wlast) begin
                        wlastPosQ.push_back(beatInBurst);
                        beatInBurst = 0;
                    end
                end else if (wvalid) begin
                    if (holdValid && wdata !== holdData) holdChanges++;
                    holdData  = wdata;
                    holdValid = 1'b1;
                    stallCycles++;
                end
                for (int c = 0; c < 4; c++) rdCount[c] += int'(rdEn[c]);
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) if (popNow[c]) wordIdx[c]++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearLog();
        awAddrQ.delete();
        awIdQ.delete();
        awLenQ.delete();
        wdataQ.delete();
        wlastPosQ.delete();
        for (int c = 0; c < 4; c++) rdCount[c] = 0;
        beatInBurst = 0;
        beatsTotal  = 0;
        holdChanges = 0;
        stallCycles = 0;
        holdValid   = 1'b0;
    endtask

    task automatic doReset();
        rstN    = 1'b0;
        chReady = 4'b0000;
        chFull  = 4'b0000;
        chVs    = 4'b0000;
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        tick(3);
        clearLog();
        rstN = 1'b1;
    endtask

    task automatic waitAw(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (awAddrQ.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic quiesce(output bit ok);
        int idleRun;
        chReady = 4'b0000;
        idleRun = 0;
        ok      = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (!awvalid && !wvalid && !bready) idleRun++;
            else                                 idleRun = 0;
            if (idleRun >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        doReset();
        compared++;
        if ({awvalid, wvalid, bready, wlast} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_valids: got %b expected 0000", {awvalid, wvalid, bready, wlast});
        end
        compared++;
        if (rdEn !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_rd_en: got %b expected 0000", rdEn);
        end
        compared++;
        if (awaddr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_awaddr: got %h expected 00000000", awaddr);
        end
        compared++;
        if ({wrFrameIdx, overrun} !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_status: got %h expected 00", {wrFrameIdx, overrun});
        end
        chReady = 4'b0001;
        waitAw(1, 40, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL midreset_wait_aw: got no address handshake expected one");
        end
        chReady = 4'b0000;
        tick(3);
        compared++;
        if (wvalid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_in_w: got wvalid=%b expected 1", wvalid);
        end
        rstN = 1'b0;
        tick(1);
        compared++;
        if ({awvalid, wvalid, bready, rdEn} !== 7'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_drop: got %b expected 0000000", {awvalid, wvalid, bready, rdEn});
        end
        doReset();
    endtask

    task automatic test_single_channel();
        bit ok;
        int w0;
        doReset();
        w0 = wordIdx[0];
        chReady = 4'b0001;
        waitAw(2, 60, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL single_wait_aw: got %0d bursts expected 2", awAddrQ.size());
        end
        quiesce(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL single_quiesce: got busy bus expected idle");
        end
        compared++;
        if (awAddrQ[0] !== 32'h0 || awIdQ[0] !== 4'hA || awLenQ[0] !== 8'd7) begin
            mismatched++;
            $display("[TB] FAIL single_aw0: got addr=%h id=%h len=%0d expected 00000000 a 7", awAddrQ[0], awIdQ[0], awLenQ[0]);
        end
        compared++;
        if (awAddrQ[1] !== 32'h100) begin
            mismatched++;
            $display("[TB] FAIL single_aw1: got %h expected 00000100", awAddrQ[1]);
        end
        compared++;
        if (wlastPosQ[0] !== 8 || wlastPosQ[1] !== 8) begin
            mismatched++;
            $display("[TB] FAIL single_wlast_pos: got %0d,%0d expected 8,8", wlastPosQ[0], wlastPosQ[1]);
        end
        compared++;
        if (rdCount[0] !== 16 || rdCount[1] + rdCount[2] + rdCount[3] !== 0) begin
            mismatched++;
            $display("[TB] FAIL single_rd_en: got ch0=%0d others=%0d expected 16 and 0", rdCount[0], rdCount[1] + rdCount[2] + rdCount[3]);
        end
        compared++;
        if (lastWstrb !== 32'hFFFFFFFF) begin
            mismatched++;
            $display("[TB] FAIL single_wstrb: got %h expected ffffffff", lastWstrb);
        end
        for (int k = 0; k < 16; k++) begin
            compared++;
            if (wdataQ[k] !== fifoWord(0, w0 + k)) begin
                mismatched++;
                $display("[TB] FAIL single_wdata%0d: got %h expected %h", k, wdataQ[k], fifoWord(0, w0 + k));
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0]  expId [5];
        logic [31:0] expAddr [5];
        expId   = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        expAddr = '{32'h0, 32'h40000, 32'h80000, 32'hC0000, 32'h100};
        doReset();
        chReady = 4'b1111;
        waitAw(5, 120, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL rr_wait_aw: got %0d bursts expected 5", awAddrQ.size());
        end
        quiesce(ok);
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (awIdQ[i] !== expId[i] || awAddrQ[i] !== expAddr[i]) begin
                mismatched++;
                $display("[TB] FAIL rr_grant%0d: got id=%h addr=%h expected id=%h addr=%h", i, awIdQ[i], awAddrQ[i], expId[i], expAddr[i]);
            end
        end
        compared++;
        if (rdCount[0] !== 16 || rdCount[2] !== 8) begin
            mismatched++;
            $display("[TB] FAIL rr_rd_en: got ch0=%0d ch2=%0d expected 16 and 8", rdCount[0], rdCount[2]);
        end
    endtask

    task automatic test_full_priority();
        bit ok;
        doReset();
        chReady = 4'b0011;
        chFull  = 4'b0010;
        waitAw(2, 60, ok);
        chFull = 4'b0000;
        waitAw(3, 60, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL full_wait_aw: got %0d bursts expected 3", awAddrQ.size());
        end
        quiesce(ok);
        compared++;
        if (awIdQ[0] !== 4'hB || awIdQ[1] !== 4'hB) begin
            mismatched++;
            $display("[TB] FAIL full_first_grants: got %h,%h expected b,b", awIdQ[0], awIdQ[1]);
        end
        compared++;
        if (awIdQ[2] !== 4'hA) begin
            mismatched++;
            $display("[TB] FAIL full_then_rr: got %h expected a", awIdQ[2]);
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        int w0;
        doReset();
        w0 = wordIdx[0];
        chReady = 4'b0001;
        waitAw(1, 40, ok);
        chReady = 4'b0000;
        for (int i = 0; i < 24; i++) begin
            wready = (i % 2 == 0);
            tick(1);
        end
        wready = 1'b1;
        quiesce(ok);
        compared++;
        if (rdCount[0] !== 8 || beatsTotal !== 8) begin
            mismatched++;
            $display("[TB] FAIL bp_beats: got rd_en=%0d beats=%0d expected 8 and 8", rdCount[0], beatsTotal);
        end
        compared++;
        if (stallCycles !== 7 || holdChanges !== 0) begin
            mismatched++;
            $display("[TB] FAIL bp_stall: got stalls=%0d changes=%0d expected 7 and 0", stallCycles, holdChanges);
        end
        compared++;
        if (wlastPosQ[0] !== 8) begin
            mismatched++;
            $display("[TB] FAIL bp_wlast: got %0d expected 8", wlastPosQ[0]);
        end
        for (int k = 0; k < 8; k++) begin
            compared++;
            if (wdataQ[k] !== fifoWord(0, w0 + k)) begin
                mismatched++;
                $display("[TB] FAIL bp_wdata%0d: got %h expected %h", k, wdataQ[k], fifoWord(0, w0 + k));
            end
        end
    endtask

    task automatic test_frame_switch();
        bit ok;
        doReset();
        chReady = 4'b0001;
        waitAw(1, 40, ok);
        chReady = 4'b0000;
        tick(2);
        chVs = 4'b0101;
        tick(1);
        chVs = 4'b0000;
        compared++;
        if (wrFrameIdx !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL fs_pending: got %b expected 0100", wrFrameIdx);
        end
        quiesce(ok);
        compared++;
        if (awAddrQ[0] !== 32'h0 || wlastPosQ[0] !== 8 || rdCount[0] !== 8) begin
            mismatched++;
            $display("[TB] FAIL fs_old_burst: got addr=%h wlast=%0d rd_en=%0d expected 00000000 8 8", awAddrQ[0], wlastPosQ[0], rdCount[0]);
        end
        compared++;
        if (wrFrameIdx !== 4'b0101) begin
            mismatched++;
            $display("[TB] FAIL fs_frame_idx: got %b expected 0101", wrFrameIdx);
        end
        chReady = 4'b0001;
        waitAw(2, 40, ok);
        quiesce(ok);
        compared++;
        if (awAddrQ[1] !== 32'h20000) begin
            mismatched++;
            $display("[TB] FAIL fs_new_addr: got %h expected 00020000", awAddrQ[1]);
        end
    endtask

    // Continues from the frame-switch state: ch0 is in its pong buffer with one burst written
    task automatic test_overrun();
        bit ok;
        clearLog();
        chReady = 4'b0001;
        waitAw(449, 449 * 12 + 200, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL ovr_wait_aw: got %0d bursts expected 449", awAddrQ.size());
        end
        tick(40);
        compared++;
        if (awAddrQ.size() !== 449 || awvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovr_blocked: got %0d bursts awvalid=%b expected 449 and 0", awAddrQ.size(), awvalid);
        end
        compared++;
        if (awAddrQ[448] !== 32'h3C100) begin
            mismatched++;
            $display("[TB] FAIL ovr_last_addr: got %h expected 0003c100", awAddrQ[448]);
        end
        compared++;
        if (overrun !== 4'b0001 || rdCount[0] !== 3592) begin
            mismatched++;
            $display("[TB] FAIL ovr_flag: got overrun=%b rd_en=%0d expected 0001 and 3592", overrun, rdCount[0]);
        end
        chVs = 4'b0001;
        tick(1);
        chVs = 4'b0000;
        compared++;
        if (wrFrameIdx !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL ovr_frame_idx: got %b expected 0100", wrFrameIdx);
        end
        waitAw(450, 40, ok);
        quiesce(ok);
        compared++;
        if (!ok || awAddrQ[449] !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL ovr_resume: got %0d bursts addr=%h expected 450 and 00000000", awAddrQ.size(), awAddrQ[449]);
        end
        compared++;
        if (overrun !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL ovr_sticky: got %b expected 0001", overrun);
        end
    endtask

    initial begin
        rstN      = 1'b0;
        chReady   = 4'b0000;
        chFull    = 4'b0000;
        chVs      = 4'b0000;
        chTransId = 16'hDCBA;
        awready   = 1'b1;
        wready    = 1'b1;
        bvalid    = 1'b1;
        holdValid = 1'b0;
        holdData  = '0;
        lastWstrb = '0;
        clearLog();
        test_reset();
        test_single_channel();
        test_round_robin();
        test_full_priority();
        test_back_pressure();
        test_frame_switch();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
